move_request_gen: RTL

Upstream input stage for the shape-move controller: synchronises and debounces the four raw direction buttons, generates press and auto-repeat move requests, and turns them into a one-cycle `trigger` with direction levels held stable for the controller's whole busy window. It sits between the board button pins and the controller's `trigger`, `l_btn`, `r_btn`, `u_btn`, `d_btn` and `busy` ports.

---
 rtl/input_pkg.sv | 30 +++
 rtl/button_debounce.sv | 95 +++++++++
 rtl/move_request_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_pkg
// Description : Shared types and constants for the move-request input stage:
//               request FSM state encoding, direction bit indices and the
//               busy-acknowledge timeout.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package input_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  // Bit positions of each direction in the pending / output masks.
  localparam int unsigned DIR_L    = 0;
  localparam int unsigned DIR_R    = 1;
  localparam int unsigned DIR_U    = 2;
  localparam int unsigned DIR_D    = 3;
  localparam int unsigned NUM_DIRS = 4;

  // Cycles to wait in WAIT_BUSY for the controller to acknowledge.
  localparam int unsigned BUSY_TIMEOUT = 4;

endpackage : input_pkg
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : One button: two-flop synchroniser, debounce counter and
//               press / auto-repeat event generator.
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset
//               raw_i    - asynchronous raw button, active-high
//               stable_o - debounced button level
//               event_o  - one-cycle press or repeat event
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000,
  parameter int unsigned CNTW            = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic event_o
);

  localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNTW-1:0] REP_DELAY = CNTW'(REPEAT_DELAY);
  localparam logic [CNTW-1:0] REP_PER   = CNTW'(REPEAT_PERIOD);
  localparam logic [CNTW-1:0] ONE       = CNTW'(1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            event_q, event_d;
  logic [CNTW-1:0] deb_q, deb_d;
  logic [CNTW-1:0] rep_q, rep_d;

  always_comb begin
    stable_d = stable_q;
    deb_d    = deb_q;
    rep_d    = rep_q;
    event_d  = 1'b0;

    // Flip only after DEBOUNCE_CYCLES consecutive disagreeing samples; the
    // >= compare keeps the counter from ever running past its terminal value.
    if (sync2_q != stable_q) begin
      if (deb_q >= DEB_LAST) begin
        stable_d = sync2_q;
        deb_d    = '0;
      end else begin
        deb_d = deb_q + ONE;
      end
    end else begin
      deb_d = '0;
    end

    // The repeat counter is loaded on the same edge the stable level rises,
    // so the first repeat lands exactly REPEAT_DELAY cycles after the press.
    if (stable_d && !stable_q) begin
      event_d = 1'b1;
      rep_d   = REP_DELAY;
    end else if (!stable_d && stable_q) begin
      rep_d = '0;  // release: no event, and a due repeat is dropped
    end else if (stable_q) begin
      if (rep_q == ONE) begin
        event_d = 1'b1;
        rep_d   = REP_PER;
      end else if (rep_q != '0) begin
        rep_d = rep_q - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      event_q  <= 1'b0;
      deb_q    <= '0;
      rep_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      event_q  <= event_d;
      deb_q    <= deb_d;
      rep_q    <= rep_d;
    end
  end

  assign stable_o = stable_q;
  assign event_o  = event_q;

endmodule : button_debounce
`default_nettype wire

// File: rtl/move_request_gen.sv
`default_nettype none
// ============================================================================
// Module      : move_request_gen
// Description : Debounces four direction buttons, collects press / repeat
//               events into a pending mask and hands them to the shape-move
//               controller as a one-cycle trigger plus a direction mask held
//               for the controller's busy window.
// Ports       : clk                          - system clock
//               rst                          - synchronous active-high reset
//               l_raw, r_raw, u_raw, d_raw   - raw buttons (async)
//               busy                         - controller busy
//               trigger                      - one-cycle move request
//               l_btn, r_btn, u_btn, d_btn   - latched direction mask
// Revision    : 1.0 - initial release
// ============================================================================
module move_request_gen
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000,
  parameter int unsigned CNTW            = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic l_raw,
  input  logic r_raw,
  input  logic u_raw,
  input  logic d_raw,
  input  logic busy,
  output logic trigger,
  output logic l_btn,
  output logic r_btn,
  output logic u_btn,
  output logic d_btn
);

  localparam logic [2:0] TMO_LAST = 3'(BUSY_TIMEOUT - 1);

  logic [NUM_DIRS-1:0] raw_w;
  logic [NUM_DIRS-1:0] evt_w;
  logic [NUM_DIRS-1:0] unused_stable;
  logic [NUM_DIRS-1:0] dir_w;

  state_e              state_q, state_d;
  logic [NUM_DIRS-1:0] pending_q, pending_d;
  logic [NUM_DIRS-1:0] mask_q, mask_d;
  logic [2:0]          tmo_q, tmo_d;

  assign raw_w[DIR_L] = l_raw;
  assign raw_w[DIR_R] = r_raw;
  assign raw_w[DIR_U] = u_raw;
  assign raw_w[DIR_D] = d_raw;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNTW            (CNTW)
    ) u_btn (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (raw_w[i]),
      .stable_o (unused_stable[i]),
      .event_o  (evt_w[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | evt_w;
    mask_d    = mask_q;
    tmo_d     = tmo_q;

    case (state_q)
      S_IDLE: begin
        // A foreign operation (busy while idle) holds requests back.
        if ((pending_q != '0) && !busy) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mask_d    = pending_q;
        pending_d = evt_w;  // new events on the clearing edge are kept
        tmo_d     = '0;
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 3'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      tmo_q     <= tmo_d;
    end
  end

  // During ISSUE the mask is not yet registered, so drive it straight from
  // pending; this makes the directions valid in the same cycle as trigger.
  always_comb begin
    case (state_q)
      S_IDLE:  dir_w = '0;
      S_ISSUE: dir_w = pending_q;
      default: dir_w = mask_q;
    endcase
  end

  assign trigger = (state_q == S_ISSUE);
  assign l_btn   = dir_w[DIR_L];
  assign r_btn   = dir_w[DIR_R];
  assign u_btn   = dir_w[DIR_U];
  assign d_btn   = dir_w[DIR_D];

endmodule : move_request_gen
`default_nettype wire
